// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, packet length width and the
// port requester FSM state encoding.
package noc_pkg;

  localparam int LEN_W = 12;

  localparam logic [2:0] FLIT_HEAD = 3'b001;
  localparam logic [2:0] FLIT_BODY = 3'b010;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } req_state_e;

endpackage

// File: rtl/flit_fifo.sv
// Show-ahead flit FIFO: rdata always presents the oldest entry while not empty.
// Push when full and pop when empty are ignored.
module flit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == {(AW+1){1'b0}});
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/port_requester.sv
// NoC port requester: buffers flits, arbitrates per packet and streams granted flits.
// Packet counters exist only when PORT_REQUESTER_STATS_EN is defined.
module port_requester
  import noc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_flit_id,
  input  logic [LEN_W-1:0]  in_length,
  output logic              req,
  input  logic              grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  output logic [15:0]       pkt_sent,
  output logic [15:0]       pkt_dropped
);

  localparam int ENT_W = DATA_W + 3 + LEN_W;

  req_state_e        state;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  wdata;
  logic [ENT_W-1:0]  rdata;
  logic [DATA_W-1:0] head_data;
  logic [2:0]        head_id;
  logic [LEN_W-1:0]  head_len;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign wdata    = {in_data, in_flit_id, in_length};
  assign {head_data, head_id, head_len} = rdata;
  assign req      = (state == ST_REQ) || (state == ST_SEND);

  flit_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .wdata(wdata),
    .rdata(rdata)
  );

  // Pop decision: discard strays in IDLE, stream while granted, flush in DRAIN.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE:  pop = !empty && (head_id != FLIT_HEAD);
      ST_REQ:   pop = 1'b0;
      ST_SEND:  pop = grant && !empty;
      ST_DRAIN: pop = !empty;
      default:  pop = 1'b0;
    endcase
  end

  // Packet FSM with registered flit output and per-packet length latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      flit_id   <= 3'b000;
      length    <= {LEN_W{1'b0}};
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty && (head_id == FLIT_HEAD)) begin
            state  <= ST_REQ;
            length <= head_len;
          end
        end
        ST_REQ: begin
          if (grant) begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Losing grant mid-packet aborts it; the rest is flushed in DRAIN.
          if (!grant) begin
            state <= ST_DRAIN;
          end else if (!empty) begin
            out_valid <= 1'b1;
            out_data  <= head_data;
            flit_id   <= head_id;
            if (head_id == FLIT_TAIL) begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (!empty && (head_id == FLIT_TAIL)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PORT_REQUESTER_STATS_EN
  logic sent_inc;
  logic drop_inc;

  assign sent_inc = (state == ST_SEND) && grant && !empty && (head_id == FLIT_TAIL);
  assign drop_inc = ((state == ST_IDLE) && !empty && (head_id != FLIT_HEAD)) ||
                    ((state == ST_SEND) && !grant);

  // Saturating packet completion and abort counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_sent    <= 16'h0000;
      pkt_dropped <= 16'h0000;
    end else begin
      if (sent_inc && (pkt_sent != 16'hFFFF)) begin
        pkt_sent <= pkt_sent + 16'd1;
      end
      if (drop_inc && (pkt_dropped != 16'hFFFF)) begin
        pkt_dropped <= pkt_dropped + 16'd1;
      end
    end
  end
`else
  assign pkt_sent    = 16'h0000;
  assign pkt_dropped = 16'h0000;
`endif

endmodule

// File: tb/tb_port_requester.sv
// Self-checking bench for port_requester: directed scenarios plus a randomized
// packet stream checked against a queue-based reference model.
module tb_port_requester;

  localparam logic [2:0] HEAD = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;
`ifdef PORT_REQUESTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  id;
    logic [11:0] len;
  } flit_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_flit_id;
  logic [11:0] in_length;
  logic        req;
  logic        grant;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic [15:0] pkt_sent;
  logic [15:0] pkt_dropped;

  int checks;
  int failures;

  port_requester #(.DATA_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_flit_id (in_flit_id),
    .in_length  (in_length),
    .req        (req),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .flit_id    (flit_id),
    .length     (length),
    .pkt_sent   (pkt_sent),
    .pkt_dropped(pkt_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    in_valid = 1'b0;
    grant    = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_flit(input logic [31:0] d, input logic [2:0] id, input logic [11:0] len);
    int   n;
    logic acc;
    in_valid   = 1'b1;
    in_data    = d;
    in_flit_id = id;
    in_length  = len;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = in_ready;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL push_timeout got accepted=%0b exp=1", acc);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    grant    = 1'b0;
    in_data  = $urandom;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req, out_valid, out_data, flit_id, length} !== 49'd0) begin
      failures++;
      $display("FAIL reset_outputs got req=%0b ov=%0b d=%h id=%b len=%0d exp all zero",
               req, out_valid, out_data, flit_id, length);
    end
    checks++;
    if (pkt_sent !== 16'd0 || pkt_dropped !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters got sent=%0d dropped=%0d exp 0 0", pkt_sent, pkt_dropped);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d [3];
    logic [2:0]  ids [3];
    int          n;
    ids[0] = HEAD; ids[1] = BODY; ids[2] = TAIL;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    do_reset();
    push_flit(d[0], HEAD, 12'd5);
    checks++;
    if (req !== 1'b0) begin
      failures++;
      $display("FAIL basic_req_early got=%0b exp=0", req);
    end
    push_flit(d[1], BODY, 12'($urandom));
    checks++;
    if (req !== 1'b1) begin
      failures++;
      $display("FAIL basic_req_rise got=%0b exp=1", req);
    end
    push_flit(d[2], TAIL, 12'($urandom));
    grant = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid, out_data, flit_id, length} !== {1'b1, d[k], ids[k], 12'd5}) begin
        failures++;
        $display("FAIL basic_flit%0d got ov=%0b d=%h id=%b len=%0d exp ov=1 d=%h id=%b len=5",
                 k, out_valid, out_data, flit_id, length, d[k], ids[k]);
      end
      if (k < 2) @(negedge clk);
    end
    checks++;
    if (req !== 1'b0 || pkt_sent !== (STATS ? 16'd1 : 16'd0)) begin
      failures++;
      $display("FAIL basic_done got req=%0b sent=%0d exp req=0 sent=%0d",
               req, pkt_sent, STATS ? 1 : 0);
    end
    @(negedge clk);
    grant = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_after got ov=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_full();
    int n_out;
    do_reset();
    push_flit($urandom, HEAD, 12'd7);
    push_flit($urandom, BODY, 12'd0);
    push_flit($urandom, BODY, 12'd0);
    push_flit($urandom, TAIL, 12'd0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_in_ready got=%0b exp=0", in_ready);
    end
    in_valid   = 1'b1;
    in_data    = $urandom;
    in_flit_id = BODY;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_fifth_blocked got in_ready=%0b exp=0", in_ready);
    end
    in_valid = 1'b0;
    grant    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_after_pop got in_ready=%0b ov=%0b exp 1 1", in_ready, out_valid);
    end
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) n_out++;
    end
    grant = 1'b0;
    checks++;
    if (n_out != 3 || req !== 1'b0 || pkt_dropped !== 16'd0) begin
      failures++;
      $display("FAIL full_rest got outs=%0d req=%0b dropped=%0d exp 3 0 0", n_out, req, pkt_dropped);
    end
  endtask

  task automatic test_drain();
    int n;
    do_reset();
    push_flit($urandom, HEAD, 12'd3);
    push_flit($urandom, BODY, 12'd0);
    push_flit($urandom, BODY, 12'd0);
    push_flit($urandom, TAIL, 12'd0);
    grant = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || flit_id !== BODY) begin
      failures++;
      $display("FAIL drain_second got ov=%0b id=%b exp ov=1 id=%b", out_valid, flit_id, BODY);
    end
    grant = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL drain_quiet got outs=%0d exp=0", n);
    end
    checks++;
    if (pkt_dropped !== (STATS ? 16'd1 : 16'd0) || pkt_sent !== 16'd0 || req !== 1'b0) begin
      failures++;
      $display("FAIL drain_counts got dropped=%0d sent=%0d req=%0b exp dropped=%0d sent=0 req=0",
               pkt_dropped, pkt_sent, req, STATS ? 1 : 0);
    end
  endtask

  task automatic test_stray();
    do_reset();
    grant = 1'b1;
    push_flit($urandom, BODY, 12'($urandom));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stray_quiet cycle %0d got req=%0b ov=%0b exp 0 0", i, req, out_valid);
      end
      @(negedge clk);
    end
    grant = 1'b0;
    checks++;
    if (pkt_dropped !== (STATS ? 16'd1 : 16'd0)) begin
      failures++;
      $display("FAIL stray_dropped got=%0d exp=%0d", pkt_dropped, STATS ? 1 : 0);
    end
  endtask

  task automatic test_rst_mid();
    int          n;
    logic [31:0] d;
    do_reset();
    push_flit($urandom, HEAD, 12'd4);
    push_flit($urandom, BODY, 12'd0);
    push_flit($urandom, BODY, 12'd0);
    push_flit($urandom, TAIL, 12'd0);
    grant = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req, out_valid, in_ready} !== 3'b001 || pkt_sent !== 16'd0 || pkt_dropped !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_state got req=%0b ov=%0b rdy=%0b sent=%0d dropped=%0d exp 0 0 1 0 0",
               req, out_valid, in_ready, pkt_sent, pkt_dropped);
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
    checks++;
    if (req !== 1'b0 || out_valid !== 1'b0 || pkt_dropped !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_flushed got req=%0b ov=%0b dropped=%0d exp 0 0 0", req, out_valid, pkt_dropped);
    end
    d = $urandom;
    push_flit(d, HEAD, 12'd9);
    push_flit($urandom, TAIL, 12'd0);
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({out_valid, out_data, flit_id, length} !== {1'b1, d, HEAD, 12'd9}) begin
      failures++;
      $display("FAIL rstmid_next got ov=%0b d=%h id=%b len=%0d exp ov=1 d=%h id=001 len=9",
               out_valid, out_data, flit_id, length, d);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    grant = 1'b0;
  endtask

  task automatic test_random();
    flit_t stim[$];
    flit_t exp_q[$];
    flit_t f;
    flit_t got;
    flit_t e;
    int    npkt;
    int    strays;
    int    idx;
    int    cyc;
    logic  granted;
    logic [11:0] plen;
    npkt   = 40;
    strays = 0;
    for (int p = 0; p < npkt; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        f.d   = $urandom;
        f.id  = ($urandom_range(0, 1) == 0) ? BODY : TAIL;
        f.len = 12'($urandom);
        stim.push_back(f);
        strays++;
      end
      plen = 12'($urandom);
      f.d = $urandom; f.id = HEAD; f.len = plen;
      stim.push_back(f);
      exp_q.push_back(f);
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        f.d = $urandom; f.id = BODY; f.len = 12'($urandom);
        stim.push_back(f);
        f.len = plen;
        exp_q.push_back(f);
      end
      f.d = $urandom; f.id = TAIL; f.len = 12'($urandom);
      stim.push_back(f);
      f.len = plen;
      exp_q.push_back(f);
    end
    do_reset();
    idx     = 0;
    cyc     = 0;
    granted = 1'b0;
    while ((idx < stim.size() || exp_q.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        got = {out_data, flit_id, length};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra got d=%h id=%b len=%0d exp no flit", out_data, flit_id, length);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL rand_flit got d=%h id=%b len=%0d exp d=%h id=%b len=%0d",
                     got.d, got.id, got.len, e.d, e.id, e.len);
          end
        end
      end
      if (!req) begin
        granted = 1'b0;
        grant   = 1'b0;
      end else if (granted) begin
        grant = 1'b1;
      end else begin
        grant   = ($urandom_range(0, 2) == 0);
        granted = grant;
      end
      if (idx < stim.size() && $urandom_range(0, 2) != 0) begin
        in_valid   = 1'b1;
        in_data    = stim[idx].d;
        in_flit_id = stim[idx].id;
        in_length  = stim[idx].len;
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
    end
    in_valid = 1'b0;
    grant    = 1'b0;
    checks++;
    if (cyc >= 5000) begin
      failures++;
      $display("FAIL rand_timeout got pushed=%0d pending=%0d exp all done", idx, exp_q.size());
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
    checks++;
    if (pkt_sent !== (STATS ? 16'(npkt) : 16'd0) || pkt_dropped !== (STATS ? 16'(strays) : 16'd0)) begin
      failures++;
      $display("FAIL rand_counts got sent=%0d dropped=%0d exp sent=%0d dropped=%0d",
               pkt_sent, pkt_dropped, STATS ? npkt : 0, STATS ? strays : 0);
    end
    checks++;
    if (req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_idle got req=%0b rdy=%0b ov=%0b exp 0 1 0", req, in_ready, out_valid);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    in_valid   = 1'b0;
    in_data    = 32'd0;
    in_flit_id = 3'b000;
    in_length  = 12'd0;
    grant      = 1'b0;
    rst        = 1'b1;
    test_reset();
    test_basic();
    test_full();
    test_drain();
    test_stray();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_requester.md
PORT_REQUESTER -- requirements
Module: port_requester

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the flit payload width.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two, at least 2), giving the flit FIFO depth.
REQ-003 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset; synchronous, active-high.
REQ-005 Port in_valid, input, 1: the upstream flit is valid.
REQ-006 Port in_ready, output, 1: the FIFO can accept a flit.
REQ-007 Port in_data, input, DATA_W: upstream flit payload.
REQ-008 Port in_flit_id, input, 3: flit type, one of HEAD=3'b001, BODY=3'b010, TAIL=3'b100.
REQ-009 Port in_length, input, 12: packet length in clock periods; meaningful only with a HEAD flit.
REQ-010 Port req, output, 1: request to the arbiter.
REQ-011 Port grant, input, 1: the arbiter has granted this port.
REQ-012 Port out_valid, output, 1: out_data, flit_id and length are valid.
REQ-013 Port out_data, output, DATA_W: granted flit payload.
REQ-014 Port flit_id, output, 3: type of the flit on out_data.
REQ-015 Port length, output, 12: length of the current packet, held for the whole packet.
REQ-016 Port pkt_sent, output, 16: packets completed.
REQ-017 Port pkt_dropped, output, 16: packets aborted.

Function
REQ-018 in_ready SHALL equal "FIFO not full", with no same-cycle bypass; a push SHALL occur only on in_valid and in_ready.
REQ-019 The FIFO SHALL store {in_data, in_flit_id, in_length} per entry and preserve order.
REQ-020 The FSM SHALL have the states IDLE, REQ, SEND and DRAIN.
REQ-021 In IDLE with a HEAD flit at the FIFO head, the FSM SHALL go to REQ and SHALL latch that entry's length.
REQ-022 In IDLE with a non-HEAD flit at the FIFO head, the FSM SHALL pop and discard that flit, stay in IDLE and increment pkt_dropped.
REQ-023 req SHALL be 1 exactly in REQ and SEND, driven from registered state.
REQ-024 In REQ with grant=1, the FSM SHALL go to SEND; otherwise it SHALL stay in REQ indefinitely.
REQ-025 In SEND with grant=1 and the FIFO not empty, the block SHALL pop one flit per cycle.
REQ-026 Each popped flit SHALL be registered onto out_data and flit_id with out_valid=1 on the cycle after the pop.
REQ-027 In SEND, out_valid SHALL be 0 on any cycle with no pop.
REQ-028 In SEND, popping a TAIL flit SHALL move the FSM to IDLE and increment pkt_sent; req SHALL fall on the next cycle.
REQ-029 In SEND, grant=0 (arbiter timeout or revoke) SHALL move the FSM to DRAIN and increment pkt_dropped.
REQ-030 In DRAIN, the block SHALL pop and discard one flit per cycle with out_valid=0 and go to IDLE after discarding a TAIL.
REQ-031 If FIFO empty occurs in SEND or DRAIN, the FSM SHALL wait in that state; this is not an error.
REQ-032 A push and a pop in the same cycle SHALL both take effect, and the occupancy SHALL be unchanged.
REQ-033 pkt_sent and pkt_dropped SHALL saturate at 16'hFFFF.
REQ-034 length SHALL be latched on entry to REQ and held until the next HEAD is accepted.

Reset
REQ-035 rst SHALL return the FSM to IDLE and empty the FIFO.
REQ-036 On rst, the outputs SHALL reset to: req=0, out_valid=0, out_data=0, flit_id=0, length=0, pkt_sent=0, pkt_dropped=0, in_ready=1 (on the cycle after rst).
REQ-037 rst asserted mid-packet SHALL discard all buffered flits, with no counter increment.

Configuration
REQ-038 The macro PORT_REQUESTER_STATS_EN SHALL control the packet counters.
REQ-039 With PORT_REQUESTER_STATS_EN defined, pkt_sent and pkt_dropped SHALL count as specified above.
REQ-040 Without PORT_REQUESTER_STATS_EN, pkt_sent and pkt_dropped SHALL be tied to 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-041 A shared package noc_pkg SHALL hold the flit-id constants FLIT_HEAD, FLIT_BODY and FLIT_TAIL, the constant LEN_W=12, and the requester state enum.
REQ-042 The FIFO SHALL be a separate sub-module flit_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, wdata, rdata) instantiated once.

Verification
REQ-043 Push HEAD(len=5), BODY, TAIL, hold grant=0 for 3 cycles, then grant=1: req rises 1 cycle after the HEAD reaches the FIFO head, and three flits with ids 001, 010, 100 appear on consecutive cycles with length=5; then req=0 and pkt_sent=1.
REQ-044 Fill the FIFO with 4 flits while grant=0: in_ready=0 and a 5th in_valid is not accepted; after one pop, in_ready=1.
REQ-045 Drop grant after the HEAD and BODY are sent (HEAD, BODY, BODY, TAIL): DRAIN discards the remaining 2 flits with out_valid=0 and pkt_dropped=1.
REQ-046 Push a stray BODY with no HEAD: it is discarded in IDLE, req stays 0 and pkt_dropped=1.
REQ-047 Assert rst mid-SEND with 3 flits buffered: the next cycle shows req=0, out_valid=0 and in_ready=1, and the counters are unchanged from their reset values.
REQ-048 Build without PORT_REQUESTER_STATS_EN and rerun REQ-043: the same flit stream is produced and pkt_sent=0.
